hazard_ctrl_unit: RTL and testbench

- Pipeline sequencing controller for the 5-stage RISC-V core; drives PC_write, IF_ID_write, IF/ID and ID/EX flush, and a global pipeline freeze.
- Detects load-use hazards (ID vs EX), branch/jump redirects (PCSrc from EX) and data-memory wait states.
- Sits beside the IF/ID front end; all outputs feed the PC register, the IF_ID register and the ID_EX/EX_MEM/MEM_WB registers.

---
 rtl/riscv_pkg.sv | 24 ++
 rtl/hazard_detect.sv | 24 ++
 rtl/hazard_ctrl_unit.sv | 157 +++++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types and constants for the RISC-V pipeline hazard controller.
package riscv_pkg;

  localparam int unsigned REG_W       = 5;
  localparam int unsigned OPC_W       = 7;
  localparam int unsigned STALL_CNT_W = 3;
  localparam int unsigned BUSY_CNT_W  = 16;
  localparam int unsigned PERF_W      = 32;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_STALL    = 2'b01,
    ST_MEM_WAIT = 2'b10
  } state_t;

  localparam logic [OPC_W-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OP_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OP_RTYPE  = 7'b0110011;
  localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection: ID-stage source operands vs. a load in EX.
module hazard_detect
  import riscv_pkg::*;
(
  input  logic             mem_read_ex,
  input  logic [REG_W-1:0] rd_ex,
  input  logic [REG_W-1:0] rs1_id,
  input  logic [REG_W-1:0] rs2_id,
  input  logic [OPC_W-1:0] opcode_id,
  output logic             hazard_c
);

  logic uses_rs1;
  logic uses_rs2;

  // Decode which source fields are real operands, then compare against the load target.
  always_comb begin
    uses_rs1 = !((opcode_id == OP_LUI) || (opcode_id == OP_AUIPC) || (opcode_id == OP_JAL));
    uses_rs2 = (opcode_id == OP_RTYPE) || (opcode_id == OP_STORE) || (opcode_id == OP_BRANCH);
    hazard_c = mem_read_ex && (rd_ex != '0) &&
               ((uses_rs1 && (rd_ex == rs1_id)) || (uses_rs2 && (rd_ex == rs2_id)));
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline sequencing controller: load-use stalls, branch squash, memory wait freeze.
// Optional performance counters are enabled with `define HAZARD_PERF_CNT_EN.
module hazard_ctrl_unit
  import riscv_pkg::*;
#(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT       = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MemRead_EX,
  input  logic [REG_W-1:0] RD_EX,
  input  logic [REG_W-1:0] RS1_ID,
  input  logic [REG_W-1:0] RS2_ID,
  input  logic [OPC_W-1:0] OPCODE_ID,
  input  logic             PCSrc,
  input  logic             mem_busy,
  output logic             PC_write,
  output logic             IF_ID_write,
  output logic             IF_ID_flush,
  output logic             ID_EX_flush,
  output logic             pipe_freeze,
  output logic             mem_timeout,
  output logic [1:0]       state_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] stall_cnt,
  output logic [PERF_W-1:0] flush_cnt,
  output logic [PERF_W-1:0] freeze_cnt
`endif
);

  localparam logic [STALL_CNT_W-1:0] STALL_RELOAD = STALL_CNT_W'(LOAD_STALL_CYCLES - 1);
  localparam logic [BUSY_CNT_W-1:0]  BUSY_LIMIT   = BUSY_CNT_W'(MEM_TIMEOUT);
  localparam logic [BUSY_CNT_W-1:0]  BUSY_MAX     = '1;

  state_t                 state_q, state_d;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;
  logic [BUSY_CNT_W-1:0]  busy_q, busy_d;
  logic                   timeout_q, timeout_d;
  logic                   hazard;

  hazard_detect u_hazard_detect (
    .mem_read_ex (MemRead_EX),
    .rd_ex       (RD_EX),
    .rs1_id      (RS1_ID),
    .rs2_id      (RS2_ID),
    .opcode_id   (OPCODE_ID),
    .hazard_c    (hazard)
  );

  // State, stall/busy counters and sticky timeout flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_RUN;
      stall_q   <= '0;
      busy_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      stall_q   <= stall_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state and pipeline control; MEM_WAIT with busy released behaves like RUN.
  always_comb begin
    state_d     = state_q;
    stall_d     = stall_q;
    busy_d      = busy_q;
    timeout_d   = timeout_q;
    PC_write    = 1'b1;
    IF_ID_write = 1'b1;
    IF_ID_flush = 1'b0;
    ID_EX_flush = 1'b0;
    pipe_freeze = 1'b0;

    case (state_q)
      ST_RUN, ST_MEM_WAIT: begin
        if (mem_busy) begin
          pipe_freeze = 1'b1;
          PC_write    = 1'b0;
          IF_ID_write = 1'b0;
          state_d     = ST_MEM_WAIT;
          if (state_q == ST_RUN) begin
            busy_d = BUSY_CNT_W'(1);
          end else if (busy_q != BUSY_MAX) begin
            busy_d = busy_q + BUSY_CNT_W'(1);
          end
        end else begin
          busy_d  = '0;
          state_d = ST_RUN;
          if (PCSrc) begin
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
          end else if (hazard) begin
            PC_write    = 1'b0;
            IF_ID_write = 1'b0;
            ID_EX_flush = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
              stall_d = STALL_RELOAD;
              state_d = ST_STALL;
            end
          end
        end
      end
      ST_STALL: begin
        PC_write    = 1'b0;
        IF_ID_write = 1'b0;
        ID_EX_flush = 1'b1;
        if (mem_busy) begin
          pipe_freeze = 1'b1;
        end else begin
          stall_d = stall_q - STALL_CNT_W'(1);
          if (stall_d == '0) begin
            state_d = ST_RUN;
          end
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    if (busy_d >= BUSY_LIMIT) begin
      timeout_d = 1'b1;
    end

    if (!reset) begin
      PC_write    = 1'b0;
      IF_ID_write = 1'b0;
      IF_ID_flush = 1'b1;
      ID_EX_flush = 1'b1;
      pipe_freeze = 1'b0;
    end
  end

  assign mem_timeout = timeout_q;
  assign state_o     = state_q;

`ifdef HAZARD_PERF_CNT_EN
  // Event counters for bubbles, squashes and frozen cycles; free-running wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      freeze_cnt <= '0;
    end else begin
      if (ID_EX_flush && !IF_ID_flush) stall_cnt <= stall_cnt + PERF_W'(1);
      if (IF_ID_flush) flush_cnt <= flush_cnt + PERF_W'(1);
      if (pipe_freeze) freeze_cnt <= freeze_cnt + PERF_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed, table-driven bench for hazard_ctrl_unit.
module tb_hazard_ctrl_unit;

  localparam logic [6:0] OPR  = 7'h33;
  localparam logic [6:0] OPLU = 7'h37;
  localparam logic [6:0] OPI  = 7'h13;
  localparam logic [6:0] OPST = 7'h23;

  // Expected output byte: {PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, pipe_freeze, state[1:0], mem_timeout}
  localparam logic [7:0] E_RST      = 8'b0011_0000;
  localparam logic [7:0] E_IDLE     = 8'b1100_0000;
  localparam logic [7:0] E_IDLE_TO  = 8'b1100_0001;
  localparam logic [7:0] E_HAZ_RUN  = 8'b0001_0000;
  localparam logic [7:0] E_HAZ_STL  = 8'b0001_0010;
  localparam logic [7:0] E_STL_FRZ  = 8'b0001_1010;
  localparam logic [7:0] E_FRZ_RUN  = 8'b0000_1000;
  localparam logic [7:0] E_FRZ_MW   = 8'b0000_1100;
  localparam logic [7:0] E_FRZ_MWTO = 8'b0000_1101;
  localparam logic [7:0] E_REL_MW   = 8'b1100_0100;
  localparam logic [7:0] E_REL_HAZ  = 8'b0001_0100;
  localparam logic [7:0] E_SQUASH   = 8'b1111_0000;
  localparam logic [7:0] E_SQ_MWTO  = 8'b1111_0101;

  logic       clk = 1'b0;
  logic       reset;
  logic       mr, pc, busy;
  logic [4:0] rd, rs1, rs2;
  logic [6:0] op;

  logic       pcw_a, ifw_a, iff_a, idf_a, frz_a, to_a;
  logic [1:0] st_a;
  logic       pcw_b, ifw_b, iff_b, idf_b, frz_b, to_b;
  logic [1:0] st_b;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] sc_a, fc_a, zc_a, sc_b, fc_b, zc_b;
`endif

  logic [7:0] out_a, out_b;
  assign out_a = {pcw_a, ifw_a, iff_a, idf_a, frz_a, st_a, to_a};
  assign out_b = {pcw_b, ifw_b, iff_b, idf_b, frz_b, st_b, to_b};

  always #5 clk = ~clk;

  hazard_ctrl_unit #(.LOAD_STALL_CYCLES(2), .MEM_TIMEOUT(3)) u_dut (
    .clk(clk), .reset(reset), .MemRead_EX(mr), .RD_EX(rd), .RS1_ID(rs1), .RS2_ID(rs2),
    .OPCODE_ID(op), .PCSrc(pc), .mem_busy(busy), .PC_write(pcw_a), .IF_ID_write(ifw_a),
    .IF_ID_flush(iff_a), .ID_EX_flush(idf_a), .pipe_freeze(frz_a), .mem_timeout(to_a),
    .state_o(st_a)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt(sc_a), .flush_cnt(fc_a), .freeze_cnt(zc_a)
`endif
  );

  hazard_ctrl_unit #(.LOAD_STALL_CYCLES(4), .MEM_TIMEOUT(255)) u_dut4 (
    .clk(clk), .reset(reset), .MemRead_EX(mr), .RD_EX(rd), .RS1_ID(rs1), .RS2_ID(rs2),
    .OPCODE_ID(op), .PCSrc(pc), .mem_busy(busy), .PC_write(pcw_b), .IF_ID_write(ifw_b),
    .IF_ID_flush(iff_b), .ID_EX_flush(idf_b), .pipe_freeze(frz_b), .mem_timeout(to_b),
    .state_o(st_b)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt(sc_b), .flush_cnt(fc_b), .freeze_cnt(zc_b)
`endif
  );

  typedef struct {
    logic       mr;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [6:0] op;
    logic       pc;
    logic       busy;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic vec_t mk(input logic m, input logic [4:0] d, input logic [4:0] s1,
                              input logic [4:0] s2, input logic [6:0] o, input logic p,
                              input logic b, input logic [7:0] e);
    vec_t v;
    v.mr = m; v.rd = d; v.rs1 = s1; v.rs2 = s2; v.op = o; v.pc = p; v.busy = b; v.exp = e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic m, input logic [4:0] d, input logic [4:0] s1,
                        input logic [4:0] s2, input logic [6:0] o, input logic p,
                        input logic b);
    mr = m; rd = d; rs1 = s1; rs2 = s2; op = o; pc = p; busy = b;
  endtask

  initial begin
    // Main sequence for u_dut (LOAD_STALL_CYCLES=2, MEM_TIMEOUT=3); one row per cycle.
    vecs.push_back(mk(0, 0, 0, 0, 0,    0, 0, E_IDLE));      // 0 idle
    vecs.push_back(mk(1, 5, 5, 0, OPR,  0, 0, E_HAZ_RUN));   // 1 load-use, bubble 1
    vecs.push_back(mk(1, 5, 5, 0, OPR,  0, 0, E_HAZ_STL));   // 2 bubble 2
    vecs.push_back(mk(0, 0, 0, 0, 0,    0, 0, E_IDLE));      // 3 back to run
    vecs.push_back(mk(1, 0, 0, 0, OPR,  0, 0, E_IDLE));      // 4 rd=x0
    vecs.push_back(mk(1, 5, 5, 0, OPLU, 0, 0, E_IDLE));      // 5 LUI has no rs1
    vecs.push_back(mk(1, 7, 1, 7, OPI,  0, 0, E_IDLE));      // 6 I-type has no rs2
    vecs.push_back(mk(1, 7, 1, 7, OPST, 0, 0, E_HAZ_RUN));   // 7 store rs2 hazard
    vecs.push_back(mk(1, 7, 1, 7, OPST, 0, 0, E_HAZ_STL));   // 8
    vecs.push_back(mk(0, 0, 0, 0, 0,    0, 0, E_IDLE));      // 9
    vecs.push_back(mk(1, 5, 5, 0, OPR,  1, 0, E_SQUASH));    // 10 PCSrc beats hazard
    vecs.push_back(mk(0, 0, 0, 0, 0,    0, 0, E_IDLE));      // 11
    vecs.push_back(mk(0, 5, 5, 0, OPR,  0, 0, E_IDLE));      // 12 not a load
    vecs.push_back(mk(0, 0, 0, 0, 0,    0, 1, E_FRZ_RUN));   // 13 busy enters wait
    vecs.push_back(mk(0, 0, 0, 0, 0,    0, 1, E_FRZ_MW));    // 14
    vecs.push_back(mk(0, 0, 0, 0, 0,    0, 0, E_REL_MW));    // 15 release, no event
    vecs.push_back(mk(0, 0, 0, 0, 0,    0, 1, E_FRZ_RUN));   // 16
    vecs.push_back(mk(1, 5, 5, 0, OPR,  0, 0, E_REL_HAZ));   // 17 release with hazard
    vecs.push_back(mk(1, 5, 5, 0, OPR,  0, 0, E_HAZ_STL));   // 18
    vecs.push_back(mk(0, 0, 0, 0, 0,    0, 0, E_IDLE));      // 19
    vecs.push_back(mk(1, 5, 5, 0, OPR,  0, 0, E_HAZ_RUN));   // 20
    vecs.push_back(mk(1, 5, 5, 0, OPR,  0, 1, E_STL_FRZ));   // 21 busy in stall holds
    vecs.push_back(mk(1, 5, 5, 0, OPR,  1, 0, E_HAZ_STL));   // 22 PCSrc ignored in stall
    vecs.push_back(mk(0, 0, 0, 0, 0,    0, 0, E_IDLE));      // 23
    vecs.push_back(mk(0, 0, 0, 0, 0,    0, 1, E_FRZ_RUN));   // 24 back-to-back busy
    vecs.push_back(mk(0, 0, 0, 0, 0,    0, 0, E_REL_MW));    // 25
    vecs.push_back(mk(0, 0, 0, 0, 0,    0, 1, E_FRZ_RUN));   // 26 counter restarts at 1
    vecs.push_back(mk(0, 0, 0, 0, 0,    0, 1, E_FRZ_MW));    // 27 count 2, no timeout
    vecs.push_back(mk(0, 0, 0, 0, 0,    0, 0, E_REL_MW));    // 28
    vecs.push_back(mk(0, 0, 0, 0, 0,    0, 0, E_IDLE));      // 29
    vecs.push_back(mk(0, 0, 0, 0, 0,    1, 1, E_FRZ_RUN));   // 30 busy x4 with PCSrc
    vecs.push_back(mk(0, 0, 0, 0, 0,    1, 1, E_FRZ_MW));    // 31
    vecs.push_back(mk(0, 0, 0, 0, 0,    1, 1, E_FRZ_MW));    // 32 third busy cycle
    vecs.push_back(mk(0, 0, 0, 0, 0,    1, 1, E_FRZ_MWTO));  // 33 timeout visible
    vecs.push_back(mk(0, 0, 0, 0, 0,    1, 0, E_SQ_MWTO));   // 34 squash on release
    vecs.push_back(mk(0, 0, 0, 0, 0,    0, 0, E_IDLE_TO));   // 35 sticky
    vecs.push_back(mk(0, 0, 0, 0, 0,    0, 0, E_IDLE_TO));   // 36

    // Reset held for three cycles.
    reset = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_hold_a", out_a, E_RST);
    chk("reset_hold_b", out_b, E_RST);
    reset = 1'b1;
    #4;
    chk("post_reset_a", out_a, E_IDLE);
    chk("post_reset_b", out_b, E_IDLE);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      set_in(vecs[i].mr, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].op, vecs[i].pc, vecs[i].busy);
      #4;
      chk($sformatf("vec%0d", i), out_a, vecs[i].exp);
    end

    // Reset clears the sticky timeout immediately.
    @(posedge clk);
    #1;
    reset = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("timeout_reset", out_a, E_RST);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #4;
    chk("timeout_cleared", out_a, E_IDLE);

    // Four bubbles with LOAD_STALL_CYCLES=4, then release.
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      set_in(1, 9, 9, 0, OPR, 0, 0);
      #4;
      chk($sformatf("lsc4_bubble%0d", k), out_b, (k == 0) ? E_HAZ_RUN : E_HAZ_STL);
    end
    @(posedge clk);
    #1;
    set_in(0, 0, 0, 0, 0, 0, 0);
    #4;
    chk("lsc4_release", out_b, E_IDLE);

    // Reset asserted mid-stall discards the pending stall.
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      set_in(1, 9, 9, 0, OPR, 0, 0);
      #4;
      chk($sformatf("midstall_pre%0d", k), out_b, (k == 0) ? E_HAZ_RUN : E_HAZ_STL);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("midstall_reset", out_b, E_RST);
    @(posedge clk);
    #1;
    reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0);
    #4;
    chk("midstall_after0", out_b, E_IDLE);
    @(posedge clk);
    #5;
    chk("midstall_after1", out_b, E_IDLE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
